traffic_phase_scheduler: RTL and testbench

Sequences right-of-way at a two-approach intersection with a pedestrian crossing. It arbitrates green time between approach A and approach B using their vehicle-presence sensors, and inserts a pedestrian walk phase on request. Every phase change goes through yellow and then all-red clearance intervals. It sits above the light-driver logic and produces the La/Lb light codes and the walk signal directly.

---
 rtl/traffic_phase_scheduler.sv | 115 +++++++++++
 tb/tb_traffic_phase_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: right-of-way sequencer for two vehicle approaches
// plus a pedestrian walk phase. Every handover goes green -> yellow -> all-red.
// Light codes: 2'b00 red, 2'b01 yellow, 2'b10 green.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 32,
    parameter int MIN_GREEN = 500000,
    parameter int MAX_GREEN = 2000000,
    parameter int YELLOW    = 500000,
    parameter int ALL_RED   = 100000,
    parameter int WALK      = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic       ped_wait
);

    typedef enum logic [2:0] {
        S_GA, S_YA, S_RA, S_GB, S_YB, S_RB, S_WK
    } state_t;

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;

    // Terminal timer values: a phase of length N ends on the edge where timer == N-1.
    localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] L_RED  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] L_WALK = CNT_W'(WALK - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_ped_pend;
    logic             r_last_side;   // 0: A was the last green, 1: B
    logic             w_change;
    logic             w_enter_wk;
    logic             w_green;

    assign w_change   = (w_next != r_state);
    assign w_enter_wk = w_change && (w_next == S_WK);
    assign w_green    = (r_state == S_GA) || (r_state == S_GB);

    // Next-state selection; greens leave only after minimum time, with
    // demand elsewhere, and once their own sensor drops or max time expires.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_GA: if ((r_timer >= L_MIN) && (req_b || r_ped_pend) &&
                      (!req_a || (r_timer == L_MAX)))
                      w_next = S_YA;
            S_YA: if (r_timer == L_YEL) w_next = S_RA;
            S_RA: if (r_timer == L_RED) w_next = r_ped_pend ? S_WK : S_GB;
            S_GB: if ((r_timer >= L_MIN) && (req_a || r_ped_pend) &&
                      (!req_b || (r_timer == L_MAX)))
                      w_next = S_YB;
            S_YB: if (r_timer == L_YEL) w_next = S_RB;
            S_RB: if (r_timer == L_RED) w_next = r_ped_pend ? S_WK : S_GA;
            S_WK: if (r_timer == L_WALK) w_next = r_last_side ? S_GA : S_GB;
            default: w_next = S_GA;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_GA;
        else      r_state <= w_next;
    end

    // Phase timer: restarts on each transition, saturates while green.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_timer <= '0;
        else if (w_change)                 r_timer <= '0;
        else if (w_green && r_timer == L_MAX) r_timer <= r_timer;
        else                               r_timer <= r_timer + 1'b1;
    end

    // Pedestrian pending: a new press on the WK-entry edge outranks the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ped_pend <= 1'b0;
        else      r_ped_pend <= ped_req || (r_ped_pend && !w_enter_wk);
    end

    // Remember which approach last went green, so a walk hands over to the other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        r_last_side <= 1'b0;
        else if (r_state == S_GA && w_next == S_YA)      r_last_side <= 1'b0;
        else if (r_state == S_GB && w_next == S_YB)      r_last_side <= 1'b1;
    end

    // Light and lamp decode from the registered state.
    always_comb begin
        La   = C_RED;
        Lb   = C_RED;
        walk = 1'b0;
        case (r_state)
            S_GA:    La = C_GRN;
            S_YA:    La = C_YEL;
            S_GB:    Lb = C_GRN;
            S_YB:    Lb = C_YEL;
            S_WK:    walk = 1'b1;
            default: ;
        endcase
    end

    assign ped_wait = r_ped_pend;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table per cycle plus a hand-written
// asynchronous-reset sequence. Inputs change on the falling edge; outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_traffic_phase_scheduler;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] La, Lb;
    logic       walk, ped_wait;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst, ra, rb, pr;
        logic [1:0] la, lb;
        logic       wk, pw;
    } vec_t;

    vec_t tbl[$];

    traffic_phase_scheduler #(
        .CNT_W(4), .MIN_GREEN(4), .MAX_GREEN(10),
        .YELLOW(3), .ALL_RED(2), .WALK(5)
    ) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
        .La(La), .Lb(Lb), .walk(walk), .ped_wait(ped_wait)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic ra, input logic rb,
                       input logic pr, input logic [1:0] la, input logic [1:0] lb,
                       input logic wk, input logic pw);
        vec_t v;
        v.rst = r; v.ra = ra; v.rb = rb; v.pr = pr;
        v.la = la; v.lb = lb; v.wk = wk; v.pw = pw;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [1:0] got,
                       input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at step %0d: got %b, expected %b", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] la,
                           input logic [1:0] lb, input logic wk, input logic pw);
        chk({tag, ".La"}, idx, La, la);
        chk({tag, ".Lb"}, idx, Lb, lb);
        chk({tag, ".walk"}, idx, {1'b0, walk}, {1'b0, wk});
        chk({tag, ".ped_wait"}, idx, {1'b0, ped_wait}, {1'b0, pw});
    endtask

    initial begin
        // Reset row, then no demand for 50 cycles: GA rests, timer saturates at 9.
        add(1,  0, 0,0,0, G,R,0,0);
        add(50, 1, 0,0,0, G,R,0,0);
        // Contention: saturated timer equals MAX-1, so GA leaves at once.
        add(1,  1, 1,1,0, G,R,0,0);
        add(3,  1, 1,1,0, Y,R,0,0);
        add(2,  1, 1,1,0, R,R,0,0);
        add(10, 1, 1,1,0, R,G,0,0);   // GB exactly MAX_GREEN
        add(3,  1, 1,1,0, R,Y,0,0);
        add(2,  1, 1,1,0, R,R,0,0);
        add(10, 1, 1,1,0, G,R,0,0);   // GA exactly MAX_GREEN
        add(1,  1, 1,1,0, Y,R,0,0);
        add(2,  1, 0,0,0, Y,R,0,0);
        add(2,  1, 0,0,0, R,R,0,0);
        add(1,  1, 0,0,0, R,G,0,0);   // GB rests with no demand
        // Reset, then single-cycle pedestrian press in GA.
        add(1,  0, 0,0,0, G,R,0,0);
        add(1,  1, 0,0,1, G,R,0,0);
        add(3,  1, 0,0,0, G,R,0,1);
        add(3,  1, 0,0,0, Y,R,0,1);
        add(2,  1, 0,0,0, R,R,0,1);
        add(2,  1, 0,0,0, R,R,1,0);
        add(1,  1, 0,0,1, R,R,1,0);   // press during walk
        add(2,  1, 0,0,0, R,R,1,1);
        add(4,  1, 0,0,0, R,G,0,1);   // green alternates to B after walk
        add(3,  1, 0,0,0, R,Y,0,1);
        add(2,  1, 0,0,0, R,R,0,1);
        add(5,  1, 0,0,0, R,R,1,0);   // second walk before green resumes
        add(1,  1, 0,0,0, G,R,0,0);   // back to A
        // Press on the very edge that enters WK: set outranks clear.
        add(1,  1, 0,0,1, G,R,0,0);
        add(2,  1, 0,0,0, G,R,0,1);
        add(3,  1, 0,0,0, Y,R,0,1);
        add(1,  1, 0,0,0, R,R,0,1);
        add(1,  1, 0,0,1, R,R,0,1);
        add(5,  1, 0,0,0, R,R,1,1);
        add(1,  1, 0,0,0, R,G,0,1);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; req_a = tbl[i].ra; req_b = tbl[i].rb; ped_req = tbl[i].pr;
            #1;
            chk_all("vec", i, tbl[i].la, tbl[i].lb, tbl[i].wk, tbl[i].pw);
        end

        // Basic handover from a fresh reset, then reset asynchronously mid-YB.
        @(negedge clk);
        rst = 1'b0; req_a = 1'b0; req_b = 1'b1; ped_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            logic [1:0] ea, eb;
            if (c > 0) @(negedge clk);
            req_a = (c >= 9); req_b = (c < 9);
            #1;
            if      (c < 4)  begin ea = G; eb = R; end
            else if (c < 7)  begin ea = Y; eb = R; end
            else if (c < 9)  begin ea = R; eb = R; end
            else if (c < 13) begin ea = R; eb = G; end
            else             begin ea = R; eb = Y; end
            chk_all("hand", c, ea, eb, 1'b0, 1'b0);
        end
        #1 rst = 1'b0;   // mid-cycle, no clock edge involved
        #1;
        chk_all("async_rst", 0, G, R, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; req_a = 1'b0; req_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk_all("restart", c, (c < 4) ? G : Y, R, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
